// File: rtl/ctrl_alu_pkg.sv
// ctrl_alu_pkg
// Shared definitions for the register-bank ALU controller: default widths,
// opcode encoding and FSM state encoding.
package ctrl_alu_pkg;

  localparam int BIT_ADDR_DEF = 8;
  localparam int BIT_DATO_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL1 = 3'b101,
    OP_SHR1 = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mult_iterativo.sv
// mult_iterativo
// Shift-add multiplier, one multiplier bit per cycle, W cycles per product.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         load a_i/b_i and begin (ignored result of any run in flight)
//   a_i, b_i        multiplicand / multiplier, W bits
//   busy_o          a product is being accumulated
//   done_o          this cycle performs the final step
//   prod_o          2*W-bit product; valid in the cycle done_o is high
//                   (it is the accumulator value being written that cycle)
module mult_iterativo #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [2*W-1:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CW'(W);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign prod_o = acc_step;

endmodule

// File: rtl/ctrl_alu_banco.sv
// ctrl_alu_banco
// Sequencer that reads two operands from an external register bank, runs one
// ALU operation and writes the result back, with a valid/ready instruction port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      instruction handshake (ready only in IDLE)
//   op, ra, rb, rd           opcode, source A/B and destination indices
//   addrRa, addrRb           bank read addresses (latched ra/rb)
//   datOutRa, datOutRb       combinational bank read data
//   addrW, datW, RegWrite    bank write port
//   done                     one-cycle retire pulse
//   flag_z, flag_c           zero / carry of the last retired result
//
// state   | meaning
// IDLE    | waiting for in_valid, in_ready=1
// READ    | read ports show ra/rb, operands captured at end of cycle
// EXEC    | compute; 1 cycle, or BIT_DATO cycles for MUL
// WRITE   | RegWrite=1 to rd, flags visible
// DONE    | done=1, back to IDLE
module ctrl_alu_banco
  import ctrl_alu_pkg::*;
#(
  parameter int BIT_ADDR = BIT_ADDR_DEF,
  parameter int BIT_DATO = BIT_DATO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [BIT_ADDR-1:0] ra,
  input  logic [BIT_ADDR-1:0] rb,
  input  logic [BIT_ADDR-1:0] rd,
  output logic [BIT_ADDR-1:0] addrRa,
  output logic [BIT_ADDR-1:0] addrRb,
  input  logic [BIT_DATO-1:0] datOutRa,
  input  logic [BIT_DATO-1:0] datOutRb,
  output logic [BIT_ADDR-1:0] addrW,
  output logic [BIT_DATO-1:0] datW,
  output logic                RegWrite,
  output logic                done,
  output logic                flag_z,
  output logic                flag_c
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [BIT_ADDR-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [BIT_DATO-1:0] a_q, a_d, b_q, b_d;
  logic [BIT_DATO-1:0] res_q, res_d;
  logic                fz_q, fz_d, fc_q, fc_d;

  logic                  mul_start, mul_busy, mul_done;
  logic [2*BIT_DATO-1:0] mul_prod;

  logic [BIT_DATO:0]   sum, diff;
  logic [BIT_DATO-1:0] alu_res;
  logic                alu_c;
  logic                exec_fin;

  // Operands come straight from the bank so the multiplier starts on the
  // same edge that captures a_q/b_q, keeping MUL at exactly BIT_DATO EXEC cycles.
  mult_iterativo #(.W(BIT_DATO)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (datOutRa),
    .b_i     (datOutRb),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  // The extra MSB of the difference is the borrow, i.e. a_q < b_q.
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:  begin alu_res = sum[BIT_DATO-1:0];  alu_c = sum[BIT_DATO];  end
      OP_SUB:  begin alu_res = diff[BIT_DATO-1:0]; alu_c = diff[BIT_DATO]; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL1: begin alu_res = {a_q[BIT_DATO-2:0], 1'b0}; alu_c = a_q[BIT_DATO-1]; end
      OP_SHR1: begin alu_res = {1'b0, a_q[BIT_DATO-1:1]}; alu_c = a_q[0]; end
      OP_MUL:  begin
        alu_res = mul_prod[BIT_DATO-1:0];
        alu_c   = |mul_prod[2*BIT_DATO-1:BIT_DATO];
      end
      default: ;
    endcase
  end

  assign exec_fin = (op_q != OP_MUL) || (mul_busy && mul_done);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    fz_d      = fz_q;
    fc_d      = fc_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(op);
          ra_d    = ra;
          rb_d    = rb;
          rd_d    = rd;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        a_d       = datOutRa;
        b_d       = datOutRb;
        mul_start = (op_q == OP_MUL);
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_fin) begin
          res_d   = alu_res;
          fz_d    = (alu_res == '0);
          fc_d    = alu_c;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign RegWrite = (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign addrRa   = ra_q;
  assign addrRb   = rb_q;
  assign addrW    = rd_q;
  assign datW     = res_q;
  assign flag_z   = fz_q;
  assign flag_c   = fc_q;

endmodule

// File: tb/tb_ctrl_alu_banco.sv
// tb_ctrl_alu_banco
// Directed bench for ctrl_alu_banco with BIT_DATO=4. The bench models the
// register bank (combinational read, write on RegWrite) preloaded with
// R1=5, R2=3, R4=F, R5=1; expected results are hand-computed constants.
module tb_ctrl_alu_banco;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] ra, rb, rd;
  logic [7:0] addrRa, addrRb, addrW;
  logic [3:0] datOutRa, datOutRb, datW;
  logic       RegWrite, done, flag_z, flag_c;

  logic [3:0] bank [256];

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_alu_banco #(.BIT_ADDR(8), .BIT_DATO(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rd       (rd),
    .addrRa   (addrRa),
    .addrRb   (addrRb),
    .datOutRa (datOutRa),
    .datOutRb (datOutRb),
    .addrW    (addrW),
    .datW     (datW),
    .RegWrite (RegWrite),
    .done     (done),
    .flag_z   (flag_z),
    .flag_c   (flag_c)
  );

  always #5 clk = ~clk;

  assign datOutRa = bank[addrRa];
  assign datOutRb = bank[addrRb];

  always @(posedge clk) begin
    if (RegWrite) bank[addrW] <= datW;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the DUT in IDLE.
  // extra = additional EXEC cycles (3 for MUL at BIT_DATO=4).
  task automatic run_instr(input string tag, input logic [2:0] op_v,
                           input logic [7:0] ra_v, input logic [7:0] rb_v,
                           input logic [7:0] rd_v, input logic [3:0] exp_w,
                           input logic exp_z, input logic exp_c,
                           input int extra, input bit hold_valid);
    check({tag, ".ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = op_v; ra = ra_v; rb = rb_v; rd = rd_v;
    tick();
    if (!hold_valid) in_valid = 1'b0;
    // Scramble the inputs: the DUT must work from the latched copy.
    op = 3'b010; ra = 8'hFF; rb = 8'hFE; rd = 8'hFD;
    for (int k = 1; k <= 4 + extra; k++) begin
      check({tag, ".ready_busy"}, 32'(in_ready), 32'd0);
      check({tag, ".addrRa"}, 32'(addrRa), 32'(ra_v));
      check({tag, ".addrRb"}, 32'(addrRb), 32'(rb_v));
      check({tag, ".regwrite"}, 32'(RegWrite), (k == 3 + extra) ? 32'd1 : 32'd0);
      check({tag, ".done"}, 32'(done), (k == 4 + extra) ? 32'd1 : 32'd0);
      if (k == 3 + extra) begin
        check({tag, ".addrW"}, 32'(addrW), 32'(rd_v));
        check({tag, ".datW"}, 32'(datW), 32'(exp_w));
      end
      if (k == 4 + extra) begin
        check({tag, ".flag_z"}, 32'(flag_z), 32'(exp_z));
        check({tag, ".flag_c"}, 32'(flag_c), 32'(exp_c));
        in_valid = 1'b0;
      end
      tick();
    end
    check({tag, ".ready_after"}, 32'(in_ready), 32'd1);
    check({tag, ".no_write_after"}, 32'(RegWrite), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) bank[i] = 4'h0;
    bank[1] = 4'h5;
    bank[2] = 4'h3;
    bank[4] = 4'hF;
    bank[5] = 4'h1;
    rst = 1'b1; in_valid = 1'b0; op = 3'b000; ra = '0; rb = '0; rd = '0;

    repeat (3) tick();
    check("rst.ready",    32'(in_ready), 32'd1);
    check("rst.regwrite", 32'(RegWrite), 32'd0);
    check("rst.done",     32'(done),     32'd0);
    check("rst.flag_z",   32'(flag_z),   32'd0);
    check("rst.flag_c",   32'(flag_c),   32'd0);
    check("rst.addrRa",   32'(addrRa),   32'd0);
    check("rst.addrRb",   32'(addrRb),   32'd0);
    check("rst.addrW",    32'(addrW),    32'd0);
    check("rst.datW",     32'(datW),     32'd0);
    rst = 1'b0;
    tick();

    run_instr("add_5_3",  3'b000, 8'd1, 8'd2, 8'd3, 4'h8, 1'b0, 1'b0, 0, 1'b0);
    run_instr("add_F_1",  3'b000, 8'd4, 8'd5, 8'd6, 4'h0, 1'b1, 1'b1, 0, 1'b0);
    run_instr("sub_3_5",  3'b001, 8'd2, 8'd1, 8'd7, 4'hE, 1'b0, 1'b1, 0, 1'b0);
    run_instr("mul_5_3",  3'b111, 8'd1, 8'd2, 8'd8, 4'hF, 1'b0, 1'b0, 3, 1'b0);
    run_instr("mul_F_F",  3'b111, 8'd4, 8'd4, 8'd9, 4'h1, 1'b0, 1'b1, 3, 1'b0);

    // Abort a MUL in its second EXEC cycle, with in_valid also high at the reset edge.
    in_valid = 1'b1; op = 3'b111; ra = 8'd1; rb = 8'd2; rd = 8'd8;
    tick();                // READ
    in_valid = 1'b0;
    tick();                // EXEC 1
    tick();                // EXEC 2
    rst = 1'b1; in_valid = 1'b1;
    tick();
    check("abort.ready",    32'(in_ready), 32'd1);
    check("abort.regwrite", 32'(RegWrite), 32'd0);
    check("abort.done",     32'(done),     32'd0);
    check("abort.addrRa",   32'(addrRa),   32'd0);
    check("abort.addrRb",   32'(addrRb),   32'd0);
    check("abort.addrW",    32'(addrW),    32'd0);
    check("abort.datW",     32'(datW),     32'd0);
    check("abort.flag_z",   32'(flag_z),   32'd0);
    check("abort.flag_c",   32'(flag_c),   32'd0);
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("abort.quiet_regwrite", 32'(RegWrite), 32'd0);
      check("abort.quiet_done",     32'(done),     32'd0);
      check("abort.quiet_ready",    32'(in_ready), 32'd1);
      tick();
    end

    run_instr("and_5_3",  3'b010, 8'd1, 8'd2, 8'd10, 4'h1, 1'b0, 1'b0, 0, 1'b0);
    run_instr("or_5_3",   3'b011, 8'd1, 8'd2, 8'd11, 4'h7, 1'b0, 1'b0, 0, 1'b0);
    run_instr("xor_5_3",  3'b100, 8'd1, 8'd2, 8'd12, 4'h6, 1'b0, 1'b0, 0, 1'b0);
    run_instr("shl_F",    3'b101, 8'd4, 8'd5, 8'd13, 4'hE, 1'b0, 1'b1, 0, 1'b0);
    run_instr("shr_1",    3'b110, 8'd5, 8'd4, 8'd14, 4'h0, 1'b1, 1'b1, 0, 1'b0);
    run_instr("sub_r1_r1",3'b001, 8'd1, 8'd1, 8'd1,  4'h0, 1'b1, 1'b0, 0, 1'b0);
    // R1 is now 0: a following read must see it; in_valid held high throughout.
    run_instr("add_hold", 3'b000, 8'd1, 8'd5, 8'd15, 4'h1, 1'b0, 1'b0, 0, 1'b1);

    check("bank.r1", 32'(bank[1]),  32'h0);
    check("bank.r8", 32'(bank[8]),  32'hF);
    check("bank.rF", 32'(bank[15]), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
